// File: rtl/instr_encoder_if.sv
// Instruction-description handshake and imem write port of the LEGv8 program loader.
// The loader connects through the slave modport; the stimulus source connects through master.
interface instr_encoder_if #(
  parameter int AW = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         kind;
  logic [4:0]         rd;
  logic [4:0]         rn;
  logic [4:0]         rm;
  logic signed [18:0] imm;
  logic               last;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [31:0]        wr_data;

  modport master (
    output in_valid, kind, rd, rn, rm, imm, last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, kind, rd, rn, rm, imm, last,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// LEGv8 program loader: encodes one instruction description per handshake into a
// 32-bit machine word and writes it to consecutive imem word addresses from 0.
module instr_encoder #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  instr_encoder_if.slave       bus,
  output logic [AW:0]          count,
  output logic                 full,
  output logic                 done,
  output logic                 err
);

  localparam logic [2:0] KIND_LDUR    = 3'd0;
  localparam logic [2:0] KIND_STUR    = 3'd1;
  localparam logic [2:0] KIND_CBZ     = 3'd2;
  localparam logic [2:0] KIND_ADD     = 3'd3;
  localparam logic [2:0] KIND_SUB     = 3'd4;
  localparam logic [2:0] KIND_AND     = 3'd5;
  localparam logic [2:0] KIND_ORR     = 3'd6;
  localparam logic [2:0] KIND_ILLEGAL = 3'd7;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FULL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // D-type offsets are 9-bit signed: the upper bits must be pure sign extension.
  function automatic logic imm_fits_d(input logic signed [18:0] v);
    return (&v[18:8]) | ~(|v[18:8]);
  endfunction

  function automatic logic is_d_type(input logic [2:0] k);
    return (k == KIND_LDUR) || (k == KIND_STUR);
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]         k,
    input logic [4:0]         rd_f,
    input logic [4:0]         rn_f,
    input logic [4:0]         rm_f,
    input logic signed [18:0] imm_f
  );
    logic [31:0] word;
    word = 32'h0;
    case (k)
      KIND_LDUR: word = {11'b11111000010, imm_f[8:0], 2'b00, rn_f, rd_f};
      KIND_STUR: word = {11'b11111000000, imm_f[8:0], 2'b00, rn_f, rd_f};
      KIND_CBZ:  word = {8'b10110100, imm_f, rd_f};
      KIND_ADD:  word = {11'b10001011000, rm_f, 6'b000000, rn_f, rd_f};
      KIND_SUB:  word = {11'b11001011000, rm_f, 6'b000000, rn_f, rd_f};
      KIND_AND:  word = {11'b10001010000, rm_f, 6'b000000, rn_f, rd_f};
      KIND_ORR:  word = {11'b10101010000, rm_f, 6'b000000, rn_f, rd_f};
      default:   word = 32'h0;
    endcase
    return word;
  endfunction

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic          in_ready;
  logic          accept;
  logic          legal;
  logic [AW:0]   count_inc;

  assign in_ready  = (state_q == ST_RUN) && !clear && !reset;
  assign accept    = bus.in_valid && in_ready;
  assign legal     = (bus.kind != KIND_ILLEGAL) && (!is_d_type(bus.kind) || imm_fits_d(bus.imm));
  assign count_inc = count_q + 1'b1;

  // Input stage: accept decision, encoding and next-state selection
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (clear) begin
      state_d   = ST_RUN;
      count_d   = '0;
      err_d     = 1'b0;
      wr_addr_d = '0;
    end else if (accept) begin
      if (legal) begin
        wr_en_d   = 1'b1;
        wr_addr_d = count_q[AW-1:0];
        wr_data_d = encode(bus.kind, bus.rd, bus.rn, bus.rm, bus.imm);
        count_d   = count_inc;
      end else begin
        err_d = 1'b1;
      end
      // A final instruction ends the program even when it was rejected.
      if (bus.last) begin
        state_d = ST_DONE;
      end else if (legal && (count_inc == DEPTH_C)) begin
        state_d = ST_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Write stage: registered imem write port and status
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'h0;
    end else begin
      count_q   <= count_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign done         = (state_q == ST_DONE);
  assign err          = err_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-loader block for the single-cycle LEGv8 processor: it accepts one instruction description per handshake (kind plus register and immediate fields) and assembles the 32-bit machine word. It writes the words into instruction memory at consecutive word addresses starting from 0. It is the encoding counterpart of the main decoder and covers the same opcode set: LDUR, STUR, CBZ, ADD, SUB, AND, ORR. It sits between the bench or boot stimulus and the imem write port.

## Interface
- DEPTH, 64, number of instruction words the target memory holds; power of two, 2..1024
- AW, 6, address width; must equal log2(DEPTH)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous restart of the write pointer and flags; does not affect memory contents
- in_valid  in  1  instruction description present
- in_ready  out  1  block can accept this cycle
- kind  in  3  0=LDUR 1=STUR 2=CBZ 3=ADD 4=SUB 5=AND 6=ORR 7=illegal
- rd  in  5  Rd (R-type) / Rt (D-type, CB)
- rn  in  5  Rn; ignored for CB
- rm  in  5  Rm; ignored for D-type and CB
- imm  in  19  two's-complement immediate; DT_address for D-type, CondBranchAddr for CB; ignored for R-type
- last  in  1  marks the final instruction of the program
- wr_en  out  1  imem write strobe
- wr_addr  out  AW  word address
- wr_data  out  32  encoded instruction
- count  out  AW+1  words written since reset/clear
- full  out  1  count == DEPTH
- done  out  1  program complete
- err  out  1  sticky: an illegal kind or an out-of-range immediate was rejected

## Operation
- Encodings:
  - R-type: {opc11, rm, 6'b0, rn, rd}, with opc11 ADD=10001011000, SUB=11001011000, AND=10001010000, ORR=10101010000.
  - D-type: {opc11, imm[8:0], 2'b00, rn, rd}, with opc11 LDUR=11111000010, STUR=11111000000.
  - CB: {8'b10110100, imm[18:0], rd}.
- Range check (D-type only): the instruction is legal only if imm[18:8] are all equal (range −256..255).
- Accept condition: in_valid && in_ready at a rising edge.
- A legal accept produces one write. An illegal kind or out-of-range immediate produces no write, sets err, and leaves count unchanged.
- States:
  - RUN: in_ready=1.
  - FULL: in_ready=0.
  - DONE: in_ready=0.
- Transitions:
  - RUN→DONE: an accept with last=1, whether legal or not. DONE takes priority over FULL.
  - RUN→FULL: a legal accept that brings count to DEPTH, with last=0.
  - FULL→RUN and DONE→RUN: clear.
  - RUN with clear=1: stays RUN and resets the pointer.
- in_ready = (state==RUN) && !clear && !reset. It is combinational from state and clear, not from in_valid.
- clear and in_valid in the same cycle: no transfer occurs; clear wins.
- clear or reset: count=0, wr_addr=0, err=0, done=0, full=0, wr_en=0 on the next edge. A write already registered for the current cycle still completes this cycle.
- Pointer: wr_addr is the low AW bits of count at accept time. It never wraps, because FULL blocks further accepts.

## Timing
- Latency 1: accept at edge N → wr_en=1 with wr_addr/wr_data valid during cycle N+1. wr_data is registered, with no combinational path from inputs.
- count, full and done update at the same edge as wr_en rises, i.e. edge N.
- Throughput is one word per cycle while in RUN, so back-to-back accepts give back-to-back writes.
- wr_en stays high for exactly one cycle per legal accept.
- Reset values: wr_en=0, wr_addr=0, wr_data=32'h0, count=0, full=0, done=0, err=0, state=RUN. in_ready reads 0 while reset is high and 1 on the first cycle after reset.
- Reset asserted mid-stream: the pending accept is discarded and everything returns to reset values on that edge.

## Test plan
- ADD rd=3 rn=1 rm=2 → next cycle wr_en=1, wr_addr=0, wr_data=0x8B020023, count=1.
- Back-to-back, one accept per cycle:
  - LDUR rd=9 rn=10 imm=8 → addr 1, 0xF8408149.
  - CBZ rd=11 imm=−4 → addr 2, 0xB4FFFF8B.
  - in_ready stays 1 throughout.
- STUR imm=300 → no wr_en, err=1, count unchanged. kind=7 → no write, err stays 1. clear → err=0.
- DEPTH=4: four consecutive legal accepts → addrs 0..3, full=1 and in_ready=0 at the edge of the 4th accept; a further in_valid is ignored. clear → count=0, in_ready=1.
- SUB with last=1 as the 2nd instruction → wr_data=0xCB...; done=1, in_ready=0. clear asserted together with in_valid → no transfer.
- Reset asserted in the cycle of an accept → no write follows; all outputs are at reset values on the next cycle.
